// File: rtl/subtractor_8bit_serial.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bi, one bit per clock,
// LSB first, with the borrow chain held in a single flip-flop.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | in_ready high; waiting for operands
// RUN    | one bit of the difference produced per cycle, cnt = bit index
// DONE   | out_valid high; Diff/Bout/Zero held until out_ready is sampled
module subtractor_8bit_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Zero
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_diff;
    logic [CW-1:0]     r_cnt;
    logic              r_br;
    logic              r_nonzero;
    logic              r_bout;
    logic              r_zero;

    logic              w_accept;
    logic              w_last;
    logic              w_a;
    logic              w_b;
    logic              w_d;
    logic              w_br_next;

    // One-bit full subtractor on the current LSBs of the operand shift registers.
    assign w_a       = r_a_sh[0];
    assign w_b       = r_b_sh[0];
    assign w_d       = w_a ^ w_b ^ r_br;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; handshake outputs decode the state register only.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN cycle.
    // Result registers only move in RUN, so they are frozen throughout DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_diff    <= '0;
            r_cnt     <= '0;
            r_br      <= 1'b0;
            r_nonzero <= 1'b0;
            r_bout    <= 1'b0;
            r_zero    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh    <= A;
            r_b_sh    <= B;
            r_br      <= Bi;
            r_cnt     <= '0;
            r_nonzero <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a_sh    <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh    <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_diff    <= {w_d, r_diff[WIDTH-1:1]};
            r_br      <= w_br_next;
            r_nonzero <= r_nonzero | w_d;
            r_cnt     <= r_cnt + CW'(1);
            if (w_last) begin
                r_bout <= w_br_next;
                r_zero <= ~(r_nonzero | w_d);
            end
        end
    end

    assign Diff = r_diff;
    assign Bout = r_bout;
    assign Zero = r_zero;

endmodule
